fa_response_checker: RTL
========================

# fa_response_checker

Self-checking response monitor that sits on the consumer end of the adder stimulus interface. Each valid cycle it samples the operands driven into the adder (`a_i`, `b_i`, `c_in_i`) and the DUT's result (`sum_i`, `carry_i`), then compares the result against a golden `a + b + c_in`. It counts mismatches, records the first failing vector, and tracks coverage of the full input space. When every input combination has been seen it raises `done_o` with a pass/fail verdict. With `WIDTH=1` it checks `Full_Adder`; with `WIDTH=4` it checks the 4-bit adder path of `add_sub_4_bit`.

## Interface
- `WIDTH`, default 1: operand width. Legal range is 1..4.
- `ERR_W`, default 8: width of the error counter.
- `CNT_W`, default 16: width of the sample counter.
- Derived localparam `NVEC = 2^(2*WIDTH+1)`: size of the input space, indexed `{a,b,c_in}`.

- `clk_i`  in  1  clock; everything updates on the rising edge.
- `rst_n_i`  in  1  reset, synchronous and active-low.
- `start_i`  in  1  one-cycle pulse that clears all state and arms checking.
- `valid_i`  in  1  the current operand/result pair is valid.
- `a_i`  in  WIDTH  operand A as applied to the DUT.
- `b_i`  in  WIDTH  operand B as applied to the DUT.
- `c_in_i`  in  1  carry-in as applied to the DUT.
- `sum_i`  in  WIDTH  DUT sum output.
- `carry_i`  in  1  DUT carry output.
- `busy_o`  out  1  checker is in the RUN state.
- `done_o`  out  1  every input combination has been covered.
- `pass_o`  out  1  `done_o` is high and `err_cnt_o` is 0.
- `err_cnt_o`  out  ERR_W  number of mismatching samples; saturates.
- `vec_cnt_o`  out  CNT_W  number of accepted samples, repeats included; saturates.
- `ff_valid_o`  out  1  a first-failure record is held.
- `ff_vec_o`  out  2*WIDTH+1  `{a,b,c_in}` of the first failing sample.
- `ff_got_o`  out  WIDTH+1  `{carry,sum}` of the first failing sample.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:** `valid_i` is ignored. `start_i` moves the FSM to RUN.
- **RUN:** a sample is accepted on each edge where `valid_i` is high.
  - Expected value is `{carry,sum} = a_i + b_i + c_in_i`, computed at WIDTH+1 bits with zero extension.
  - The sample mismatches if `{carry_i,sum_i}` differs from the expected value.
  - On a mismatch, `err_cnt_o` increments, saturating at `2^ERR_W-1`.
  - On the first mismatch only, `ff_vec_o` and `ff_got_o` are loaded and `ff_valid_o` is set. Later mismatches do not overwrite the record.
  - `vec_cnt_o` increments on every accepted sample, saturating at `2^CNT_W-1`.
  - Coverage bit `cov[{a_i,b_i,c_in_i}]` is set on every accepted sample. Repeated vectors are checked and counted but add no coverage.
  - When the last missing coverage bit is set, the FSM moves to DONE. That final sample is still fully checked.
- **DONE:** `done_o` is 1 and `valid_i` is ignored. All counters and the first-failure record hold until `start_i`.
- **`start_i` in any state** clears `cov`, `err_cnt_o`, `vec_cnt_o`, `ff_*` and `pass_o`, then enters RUN. If `valid_i` is high in the same cycle, that sample is dropped: start has priority over the sample.
- **Unknown inputs:** an X or Z on any sampled input while `valid_i` is high counts as a mismatch. This is checked with `!==` in simulation only. Synthesis behaviour is plain compare.

## Timing
- Reset values:
  - state = IDLE; `busy_o` = 0, `done_o` = 0, `pass_o` = 0.
  - `err_cnt_o` = 0, `vec_cnt_o` = 0.
  - `ff_valid_o` = 0, `ff_vec_o` = 0, `ff_got_o` = 0; `cov` = 0.
- All outputs are registered. A sample accepted at edge N is reflected on the outputs after edge N, visible in cycle N+1.
- `busy_o` rises the cycle after the `start_i` edge.
- `done_o` and `pass_o` rise the cycle after the edge that accepts the covering sample. `busy_o` falls in that same cycle.
- There is no backpressure: one sample per cycle is accepted indefinitely, for a throughput of 1 per cycle.
- If `rst_n_i` goes low during RUN, the next edge forces reset values regardless of `start_i` or `valid_i`.

## Test plan
- **Exhaustive sweep, WIDTH=1:** pulse `start_i`, then drive all 8 `{a,b,c_in}` combinations in order with a correct adder model.
  - Required: `done_o=1`, `pass_o=1`, `err_cnt_o=0`, `vec_cnt_o=8`, one cycle after the 8th sample.
- **Injected fault, WIDTH=1:** full sweep with `carry_i` forced to 0.
  - Required: `err_cnt_o=4` (failing vectors 011, 101, 110, 111), `ff_vec_o=3'b011`, `ff_got_o=2'b00`, `ff_valid_o=1`, `pass_o=0`, `done_o=1`.
- **Repeats and gaps, WIDTH=1:** send vector 000 five times, hold `valid_i` low for 3 cycles, then send the remaining 7 vectors.
  - Required: `vec_cnt_o=12`, and `done_o` rises only after the 12th sample.
- **Ignored inputs:** send valid samples while in IDLE, and again after DONE.
  - Required: no counter changes. Then `start_i` with `valid_i`=1 in the same cycle drops that sample, so `vec_cnt_o=0`.
- **WIDTH=4 sweep:** drive all 512 vectors in random order with one wrong result at `a=4'hF, b=4'h1, c_in=0`, where the DUT returns `{0,0000}` instead of `{1,0000}`.
  - Required: `err_cnt_o=1`, `ff_vec_o=9'b1111_0001_0`, `done_o=1`, `pass_o=0`.
- **Reset mid-run:** deassert `rst_n_i` for one cycle after 3 samples.
  - Required: all outputs return to their reset values, and the state stays IDLE until the next `start_i`.

Source files
------------

// File: rtl/fa_response_checker.sv
// -----------------------------------------------------------------------------
// fa_response_checker
//
// Response monitor for the consumer end of the adder stimulus interface.
// Each cycle with valid_i high, it samples the operands driven into the adder
// and the adder's result. It compares that result against a golden
// a + b + c_in and counts mismatches. It keeps the first failing vector and
// builds a coverage map of the full {a,b,c_in} input space. When every input
// combination has been seen, the checker stops accepting samples and reports
// a pass/fail verdict.
//
// WIDTH = 1 checks Full_Adder. WIDTH = 4 checks the adder path of
// add_sub_4_bit. The legal range of WIDTH is 1..4.
//
// Ports
//   clk_i       rising-edge clock
//   rst_n_i     synchronous active-low reset
//   start_i     one-cycle pulse: clears all state and arms checking
//   valid_i     operand/result pair on the inputs is valid
//   a_i, b_i    operands as applied to the adder (WIDTH bits)
//   c_in_i      carry-in as applied to the adder
//   sum_i       adder sum output (WIDTH bits)
//   carry_i     adder carry output
//   busy_o      checker is in RUN
//   done_o      every input combination has been covered
//   pass_o      done with zero mismatches
//   err_cnt_o   saturating mismatch count
//   vec_cnt_o   saturating accepted-sample count, repeats included
//   ff_valid_o  a first-failure record is held
//   ff_vec_o    {a,b,c_in} of the first failing sample
//   ff_got_o    {carry,sum} of the first failing sample
// -----------------------------------------------------------------------------
module fa_response_checker #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               c_in_i,
  input  logic [WIDTH-1:0]   sum_i,
  input  logic               carry_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_cnt_o,
  output logic [CNT_W-1:0]   vec_cnt_o,
  output logic               ff_valid_o,
  output logic [2*WIDTH:0]   ff_vec_o,
  output logic [WIDTH:0]     ff_got_o
);

  localparam int VEC_W = 2 * WIDTH + 1;
  localparam int NVEC  = 1 << VEC_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Golden result, computed at WIDTH+1 bits with zero extension.
  function automatic logic [WIDTH:0] golden_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             c
  );
    golden_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  // Saturating increment of the error counter.
  function automatic logic [ERR_W-1:0] err_inc_sat(input logic [ERR_W-1:0] v);
    if (&v) begin
      err_inc_sat = v;
    end else begin
      err_inc_sat = v + ERR_W'(1'b1);
    end
  endfunction

  // Saturating increment of the sample counter.
  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] v);
    if (&v) begin
      cnt_inc_sat = v;
    end else begin
      cnt_inc_sat = v + CNT_W'(1'b1);
    end
  endfunction

  // Registered state
  logic [1:0]       state_r;
  logic [NVEC-1:0]  cov_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] vec_cnt_r;
  logic             ff_valid_r;
  logic [VEC_W-1:0] ff_vec_r;
  logic [WIDTH:0]   ff_got_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  // Next-state values
  logic [1:0]       state_s;
  logic [NVEC-1:0]  cov_s;
  logic [ERR_W-1:0] err_cnt_s;
  logic [CNT_W-1:0] vec_cnt_s;
  logic             ff_valid_s;
  logic [VEC_W-1:0] ff_vec_s;
  logic [WIDTH:0]   ff_got_s;
  logic             busy_s;
  logic             done_s;
  logic             pass_s;

  // Per-sample datapath
  logic [VEC_W-1:0] vec_idx_s;
  logic [WIDTH:0]   exp_s;
  logic [WIDTH:0]   got_s;
  logic             mismatch_s;
  logic             accept_s;

  // Sample decode: coverage index, golden value and result compare.
  always_comb begin
    vec_idx_s = {a_i, b_i, c_in_i};
    exp_s     = golden_sum(a_i, b_i, c_in_i);
    got_s     = {carry_i, sum_i};
    // Case inequality flags X/Z on any sampled input as a mismatch in
    // four-state simulation. In hardware it reduces to a plain compare.
    mismatch_s = (got_s !== exp_s);
    accept_s   = (state_r == ST_RUN) && valid_i && !start_i;
  end

  // Next-state logic: start clears and arms; RUN accepts samples.
  always_comb begin
    state_s    = state_r;
    cov_s      = cov_r;
    err_cnt_s  = err_cnt_r;
    vec_cnt_s  = vec_cnt_r;
    ff_valid_s = ff_valid_r;
    ff_vec_s   = ff_vec_r;
    ff_got_s   = ff_got_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;

    if (start_i) begin
      // Start wins over a same-cycle sample, which is dropped.
      state_s    = ST_RUN;
      cov_s      = {NVEC{1'b0}};
      err_cnt_s  = {ERR_W{1'b0}};
      vec_cnt_s  = {CNT_W{1'b0}};
      ff_valid_s = 1'b0;
      ff_vec_s   = {VEC_W{1'b0}};
      ff_got_s   = {(WIDTH+1){1'b0}};
      busy_s     = 1'b1;
      done_s     = 1'b0;
      pass_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_s = 1'b0;
          done_s = 1'b0;
        end
        ST_RUN: begin
          if (accept_s) begin
            vec_cnt_s = cnt_inc_sat(vec_cnt_r);
            if (mismatch_s) begin
              err_cnt_s = err_inc_sat(err_cnt_r);
              if (!ff_valid_r) begin
                ff_valid_s = 1'b1;
                ff_vec_s   = vec_idx_s;
                ff_got_s   = got_s;
              end else begin
                ff_valid_s = ff_valid_r;
              end
            end else begin
              err_cnt_s = err_cnt_r;
            end
            cov_s[vec_idx_s] = 1'b1;
            // The sample that fills the last hole completes the run.
            if (&cov_s) begin
              state_s = ST_DONE;
              busy_s  = 1'b0;
              done_s  = 1'b1;
              pass_s  = (err_cnt_s == {ERR_W{1'b0}});
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          busy_s = 1'b0;
          done_s = 1'b1;
        end
        default: begin
          // An illegal encoding falls back to a clean IDLE.
          state_s    = ST_IDLE;
          cov_s      = {NVEC{1'b0}};
          err_cnt_s  = {ERR_W{1'b0}};
          vec_cnt_s  = {CNT_W{1'b0}};
          ff_valid_s = 1'b0;
          ff_vec_s   = {VEC_W{1'b0}};
          ff_got_s   = {(WIDTH+1){1'b0}};
          busy_s     = 1'b0;
          done_s     = 1'b0;
          pass_s     = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      cov_r      <= {NVEC{1'b0}};
      err_cnt_r  <= {ERR_W{1'b0}};
      vec_cnt_r  <= {CNT_W{1'b0}};
      ff_valid_r <= 1'b0;
      ff_vec_r   <= {VEC_W{1'b0}};
      ff_got_r   <= {(WIDTH+1){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cov_r      <= cov_s;
      err_cnt_r  <= err_cnt_s;
      vec_cnt_r  <= vec_cnt_s;
      ff_valid_r <= ff_valid_s;
      ff_vec_r   <= ff_vec_s;
      ff_got_r   <= ff_got_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      pass_r     <= pass_s;
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign pass_o     = pass_r;
  assign err_cnt_o  = err_cnt_r;
  assign vec_cnt_o  = vec_cnt_r;
  assign ff_valid_o = ff_valid_r;
  assign ff_vec_o   = ff_vec_r;
  assign ff_got_o   = ff_got_r;

endmodule
